// File: rtl/clb_cluster.sv
// Purpose: cluster of N K-input LUT BLEs with optional output flops, loaded by a serial config shifter.
// Latency: combinational BLEs are in->out same cycle; registered BLEs add one cycle; cfg_done rises the cycle after the last accepted bit.
// Backpressure: cfg_ready is high only while loading; cfg_valid gaps stall the load. Optional CLB_CHAIN_OUT_EN adds the cfg_dout chain port.
module clb_cluster #(
    parameter int K = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           res,
    input  logic           cfg_start,
    input  logic           cfg_din,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    output logic           cfg_done,
    input  logic           clr,
    input  logic [N*K-1:0] in,
    output logic [N-1:0]   out
`ifdef CLB_CHAIN_OUT_EN
    ,
    output logic           cfg_dout
`endif
);

    localparam int TT_W  = 1 << K;
    localparam int BLE_W = TT_W + 2;
    localparam int CFG_W = N * BLE_W;
    localparam int CNT_W = $clog2(CFG_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CFG_W-1:0]   cfg_reg;
    logic [CFG_W-1:0]   cfg_shift;
    logic [CNT_W-1:0]   count;
    logic [N-1:0]       q;
    logic [N-1:0]       lut;
    logic [N-1:0]       use_ff;
    logic [N-1:0]       ff_init_cur;
    logic [N-1:0]       ff_init_new;
    logic               accept;
    logic               last_beat;

    // cfg_start outranks a simultaneous beat, so the beat is dropped entirely
    assign accept    = cfg_valid && (state_q == S_LOAD) && !cfg_start;
    assign last_beat = accept && (count == LAST);
    assign cfg_shift = {cfg_din, cfg_reg[CFG_W-1:1]};

    for (genvar g = 0; g < N; g++) begin : g_ble
        logic [TT_W-1:0] tt;
        logic [K-1:0]    sel;
        assign tt             = cfg_reg[g*BLE_W +: TT_W];
        assign sel            = in[g*K +: K];
        assign lut[g]         = tt[sel];
        assign use_ff[g]      = cfg_reg[g*BLE_W + TT_W];
        assign ff_init_cur[g] = cfg_reg[g*BLE_W + TT_W + 1];
        // init bit as it will be after this edge's shift, for the load-completing edge
        assign ff_init_new[g] = cfg_shift[g*BLE_W + TT_W + 1];
    end

`ifdef CLB_CHAIN_OUT_EN
    // next bit to leave the shifter; lets clusters chain and old config be read back
    assign cfg_dout = cfg_reg[0];
`endif

    // state register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake/status outputs
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        out       = '0;
        if (cfg_start) begin
            state_d = S_LOAD;
        end else if (last_beat) begin
            state_d = S_RUN;
        end
        if (state_q == S_LOAD) begin
            cfg_ready = 1'b1;
        end
        if (state_q == S_RUN) begin
            cfg_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                out[i] = use_ff[i] ? q[i] : lut[i];
            end
        end
    end

    // config shifter, bit counter and BLE flops
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cfg_reg <= '0;
            count   <= '0;
            q       <= '0;
        end else if (cfg_start) begin
            count <= '0;
            q     <= '0;
        end else if (accept) begin
            cfg_reg <= cfg_shift;
            if (last_beat) begin
                count <= '0;
                q     <= ff_init_new;
            end else begin
                count <= count + 1'b1;
            end
        end else if (state_q == S_RUN) begin
            q <= clr ? ff_init_cur : lut;
        end
    end

endmodule

// File: tb/tb_clb_cluster.sv
module tb_clb_cluster;

    localparam int K  = 4;
    localparam int N  = 4;
    localparam int BW = 18;
    localparam int CW = N * BW;

    logic           clk = 1'b0;
    logic           res;
    logic           cfg_start;
    logic           cfg_din;
    logic           cfg_valid;
    logic           cfg_ready;
    logic           cfg_done;
    logic           clr;
    logic [N*K-1:0] in;
    logic [N-1:0]   out;
`ifdef CLB_CHAIN_OUT_EN
    logic           cfg_dout;
`endif

    int checks = 0;
    int errors = 0;

    // reference model: image of loaded bits, phase flags, flop values
    logic [CW-1:0] img;
    bit            mload;
    bit            mrun;
    logic [N-1:0]  mq;
    int            mcnt;

    logic [CW-1:0] cfg_a, cfg_b, cfg_c, cfg_d;

    clb_cluster #(.K(K), .N(N)) dut (
        .clk       (clk),
        .res       (res),
        .cfg_start (cfg_start),
        .cfg_din   (cfg_din),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .clr       (clr),
        .in        (in),
        .out       (out)
`ifdef CLB_CHAIN_OUT_EN
        ,
        .cfg_dout  (cfg_dout)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] ble(input int i, input logic [15:0] tt, input bit uff, input bit init);
        logic [CW-1:0] r;
        r = '0;
        r[i*BW +: 16] = tt;
        r[i*BW + 16]  = uff;
        r[i*BW + 17]  = init;
        return r;
    endfunction

    function automatic logic [N-1:0] m_lut();
        logic [N-1:0] r;
        logic [15:0]  tbl;
        logic [K-1:0] sel;
        for (int i = 0; i < N; i++) begin
            tbl  = img[i*BW +: 16];
            sel  = in[i*K +: K];
            r[i] = tbl[sel];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] m_init();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = img[i*BW + 17];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_out();
        logic [N-1:0] r;
        logic [N-1:0] l;
        r = '0;
        l = m_lut();
        if (mrun) begin
            for (int i = 0; i < N; i++) begin
                if (img[i*BW + 16]) r[i] = mq[i];
                else                r[i] = l[i];
            end
        end
        return r;
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk_v("out", out, exp_out());
        chk_b("cfg_ready", cfg_ready, mload);
        chk_b("cfg_done", cfg_done, mrun);
`ifdef CLB_CHAIN_OUT_EN
        chk_b("cfg_dout", cfg_dout, img[0]);
`endif
    endtask

    task automatic m_reset();
        img   = '0;
        mload = 1'b0;
        mrun  = 1'b0;
        mq    = '0;
        mcnt  = 0;
    endtask

    // advance the model by one edge using the inputs currently driven, then the DUT
    task automatic tick();
        if (cfg_start) begin
            mload = 1'b1;
            mrun  = 1'b0;
            mcnt  = 0;
            mq    = '0;
        end else if (mload && cfg_valid) begin
            img  = {cfg_din, img[CW-1:1]};
            mcnt = mcnt + 1;
            if (mcnt == CW) begin
                mload = 1'b0;
                mrun  = 1'b1;
                mq    = m_init();
            end
        end else if (mrun) begin
            mq = clr ? m_init() : m_lut();
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic start_load(input bit with_beat);
        cfg_start = 1'b1;
        cfg_valid = with_beat;
        cfg_din   = 1'b1;
        clr       = 1'($urandom);
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [CW-1:0] bits, input int nb, input bit stall);
        int b   = 0;
        int cyc = 0;
        while (b < nb) begin
            if (stall && (cyc % 3 == 2)) begin
                cfg_valid = 1'b0;
                cfg_din   = 1'($urandom);
            end else begin
                cfg_valid = 1'b1;
                cfg_din   = bits[b];
                b++;
            end
            clr = 1'($urandom);
            in  = (N*K)'($urandom);
            cyc++;
            tick();
        end
        cfg_valid = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic run_rand(input int n);
        repeat (n) begin
            in        = (N*K)'($urandom);
            clr       = ($urandom_range(3) == 0);
            cfg_valid = 1'($urandom);
            cfg_din   = 1'($urandom);
            #1;
            check_all();
            tick();
        end
        clr       = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] xe;
        res = 1'b0; cfg_start = 1'b0; cfg_din = 1'b0; cfg_valid = 1'b0; clr = 1'b0; in = '0;
        m_reset();
        #3;
        check_all();
        chk_v("reset_out", out, '0);
        #10;
        res = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // valid while idle is ignored
        cfg_valid = 1'b1; cfg_din = 1'b1; clr = 1'b1;
        tick();
        cfg_valid = 1'b0; clr = 1'b0;

        // combinational XOR on BLE0
        cfg_a = ble(0, 16'h6666, 1'b0, 1'b0);
        start_load(1'b0);
        send(cfg_a, CW, 1'b0);
        xe = 4'b0110;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] v2;
            v2 = v[1:0];
            in = (N*K)'(v2);
            #1;
            check_all();
            chk_b("xor_out0", out[0], xe[v2]);
            chk_v("xor_upper", {1'b0, out[3:1]}, '0);
        end
        tick();

        // registered AND on BLE1, init/clear on BLE2, stalled load
        cfg_b = ble(0, 16'h6666, 1'b0, 1'b0) | ble(1, 16'h8888, 1'b1, 1'b0) | ble(2, 16'h0000, 1'b1, 1'b1);
        in = '0;
        start_load(1'b0);
        send(cfg_b, CW, 1'b1);
        in = '0;
        #1;
        chk_b("init_first", out[2], 1'b1);
        tick();
        chk_b("init_after_edge", out[2], 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_b("clr_reload", out[2], 1'b1);
        tick();
        chk_b("clr_one_cycle", out[2], 1'b0);
        in = 16'h0030;
        #1;
        chk_b("and_pre_edge", out[1], 1'b0);
        tick();
        chk_b("and_11", out[1], 1'b1);
        in = 16'h0010;
        #1;
        chk_b("and_hold", out[1], 1'b1);
        tick();
        chk_b("and_01", out[1], 1'b0);

        // random configuration and random run-time traffic
        cfg_c = CW'({$urandom, $urandom, $urandom});
        start_load(1'b0);
        send(cfg_c, CW, 1'b1);
        run_rand(40);

        // reset in the middle of a load
        cfg_d = CW'({$urandom, $urandom, $urandom});
        start_load(1'b0);
        send(cfg_d, 30, 1'b0);
        res = 1'b0;
        m_reset();
        #1;
        check_all();
        chk_v("rst_mid_out", out, '0);
        #4;
        res = 1'b1;
        @(posedge clk);
        #1;
        check_all();
        start_load(1'b0);
        send(cfg_b, CW, 1'b0);
        run_rand(20);

        // restart mid-load, with a beat colliding with cfg_start
        start_load(1'b0);
        send(cfg_d, 20, 1'b0);
        start_load(1'b1);
        send(cfg_c, CW, 1'b0);
        run_rand(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
